restoring_divider: RTL and testbench



---
 rtl/div_pkg.sv | 13 +
 rtl/add_sub9.sv | 23 ++
 rtl/restoring_divider.sv | 141 ++++++++++++++
 tb/tb_restoring_divider.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the restoring divider.
package div_pkg;

  localparam int DIV_W = 8;
  localparam logic [2:0] DIV_LAST = 3'(DIV_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/add_sub9.sv
// 9-bit ripple add/subtract unit: S = A + (B ^ {9{sub}}) + sub, built from full-adder cells.
module add_sub9 (
  input  logic [8:0] A,
  input  logic [8:0] B,
  input  logic       sub,
  output logic [8:0] S,
  output logic       cout
);

  logic [8:0] w_b;
  logic [9:0] w_c;

  assign w_b    = B ^ {9{sub}};
  assign w_c[0] = sub;

  for (genvar i = 0; i < 9; i++) begin : g_fa
    assign S[i]     = A[i] ^ w_b[i] ^ w_c[i];
    assign w_c[i+1] = (A[i] & w_b[i]) | (w_c[i] & (A[i] ^ w_b[i]));
  end

  assign cout = w_c[9];

endmodule

// File: rtl/restoring_divider.sv
// 8-bit unsigned restoring divider: one quotient bit per clock, level Start/Done handshake.
module restoring_divider
  import div_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [DIV_W-1:0] Dividend,
  input  logic [DIV_W-1:0] Divisor,
  output logic [DIV_W-1:0] Quotient,
  output logic [DIV_W-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             Div0
);

  div_state_t       r_state;
  div_state_t       w_next;
  logic [DIV_W:0]   r_r;
  logic [DIV_W-1:0] r_q;
  logic [DIV_W-1:0] r_d;
  logic [2:0]       r_cnt;
  logic             r_div0;

  logic [DIV_W:0]   w_rs;
  logic [DIV_W:0]   w_diff;
  logic             w_cout;
  logic             w_unused;

  // R[8] is always 0 between iterations, so only R[7:0] feeds the shift.
  assign w_unused = r_r[DIV_W];
  assign w_rs     = {r_r[DIV_W-1:0], r_q[DIV_W-1]};

  add_sub9 u_add_sub9 (
    .A    (w_rs),
    .B    ({1'b0, r_d}),
    .sub  (1'b1),
    .S    (w_diff),
    .cout (w_cout)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_next = (Divisor == 8'd0) ? DONE : CALC;
        end else begin
          w_next = IDLE;
        end
      end
      CALC: begin
        if (r_cnt == DIV_LAST) begin
          w_next = DONE;
        end else begin
          w_next = CALC;
        end
      end
      DONE: begin
        if (!Start) begin
          w_next = IDLE;
        end else begin
          w_next = DONE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_r    <= 9'd0;
      r_q    <= 8'd0;
      r_d    <= 8'd0;
      r_cnt  <= 3'd0;
      r_div0 <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_d   <= Divisor;
            r_cnt <= 3'd0;
            // A zero divisor short-circuits to the saturated quotient convention.
            if (Divisor == 8'd0) begin
              r_q    <= 8'hFF;
              r_r    <= {1'b0, Dividend};
              r_div0 <= 1'b1;
            end else begin
              r_q    <= Dividend;
              r_r    <= 9'd0;
              r_div0 <= 1'b0;
            end
          end
        end
        CALC: begin
          r_cnt <= r_cnt + 3'd1;
          if (w_cout) begin
            r_r <= w_diff;
            r_q <= {r_q[DIV_W-2:0], 1'b1};
          end else begin
            r_r <= w_rs;
            r_q <= {r_q[DIV_W-2:0], 1'b0};
          end
        end
        DONE: begin
          if (!Start) begin
            r_div0 <= 1'b0;
          end
        end
        default: begin
          r_div0 <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    Quotient  = r_q;
    Remainder = r_r[DIV_W-1:0];
    Busy      = 1'b0;
    Done      = 1'b0;
    Div0      = 1'b0;
    case (r_state)
      CALC:    Busy = 1'b1;
      DONE: begin
        Done = 1'b1;
        Div0 = r_div0;
      end
      default: Busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed cases plus randomized divides vs. / and %.
module tb_restoring_divider;

  logic       Clk;
  logic       Reset_n;
  logic       Start;
  logic [7:0] Dividend;
  logic [7:0] Divisor;
  logic [7:0] Quotient;
  logic [7:0] Remainder;
  logic       Busy;
  logic       Done;
  logic       Div0;

  int n_vec = 0;
  int n_err = 0;

  restoring_divider dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Busy      (Busy),
    .Done      (Done),
    .Div0      (Div0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference: plain integer arithmetic, zero divisor gives FF / dividend.
  function automatic logic [7:0] ref_q(input logic [7:0] a, input logic [7:0] b);
    return (b == 8'd0) ? 8'hFF : 8'(a / b);
  endfunction

  function automatic logic [7:0] ref_r(input logic [7:0] a, input logic [7:0] b);
    return (b == 8'd0) ? a : 8'(a % b);
  endfunction

  // Pulse Start for one edge, then wait (bounded) for Done; reports cycles and Busy samples.
  task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                        output int cyc, output int busy_n);
    @(negedge Clk);
    Dividend = a;
    Divisor  = b;
    Start    = 1'b1;
    @(posedge Clk); #1;
    Start  = 1'b0;
    cyc    = 0;
    busy_n = 0;
    while (Done !== 1'b1 && cyc < 20) begin
      if (Busy === 1'b1) busy_n++;
      @(posedge Clk); #1;
      cyc++;
    end
    if (Busy === 1'b1) busy_n++;
  endtask

  task automatic test_reset();
    Reset_n  = 1'b0;
    Start    = 1'b0;
    Dividend = 8'd0;
    Divisor  = 8'd0;
    repeat (3) @(posedge Clk);
    #1;
    n_vec++;
    if ({Quotient, Remainder, Busy, Done, Div0} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got Q=%h R=%h B=%b D=%b Z=%b, expected all 0",
               Quotient, Remainder, Busy, Done, Div0);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [7:0] ta [5];
    logic [7:0] tb [5];
    int cyc, bn;
    ta = '{8'd200, 8'd255, 8'd255, 8'd5, 8'd0};
    tb = '{8'd7,   8'd1,   8'd255, 8'd10, 8'd3};
    for (int i = 0; i < 5; i++) begin
      do_div(ta[i], tb[i], cyc, bn);
      n_vec++;
      if (cyc !== 8 || bn !== 8) begin
        n_err++;
        $display("FAIL dir_latency %0d/%0d: got cycles=%0d busy=%0d, expected 8/8",
                 ta[i], tb[i], cyc, bn);
      end
      n_vec++;
      if (Quotient !== ref_q(ta[i], tb[i]) || Remainder !== ref_r(ta[i], tb[i]) || Div0 !== 1'b0) begin
        n_err++;
        $display("FAIL dir_result %0d/%0d: got Q=%0d R=%0d Z=%b, expected Q=%0d R=%0d Z=0",
                 ta[i], tb[i], Quotient, Remainder, Div0, ref_q(ta[i], tb[i]), ref_r(ta[i], tb[i]));
      end
      @(posedge Clk); #1;
      n_vec++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
        n_err++;
        $display("FAIL dir_return_idle: got Done=%b Busy=%b, expected 0/0", Done, Busy);
      end
    end
  endtask

  task automatic test_div0();
    int cyc, bn;
    do_div(8'h80, 8'h00, cyc, bn);
    n_vec++;
    if (cyc !== 0 || bn !== 0) begin
      n_err++;
      $display("FAIL div0_latency: got cycles=%0d busy=%0d, expected 0/0", cyc, bn);
    end
    n_vec++;
    if (Quotient !== 8'hFF || Remainder !== 8'h80 || Div0 !== 1'b1) begin
      n_err++;
      $display("FAIL div0_result: got Q=%h R=%h Z=%b, expected Q=ff R=80 Z=1",
               Quotient, Remainder, Div0);
    end
    @(posedge Clk); #1;
    n_vec++;
    if (Done !== 1'b0 || Div0 !== 1'b0) begin
      n_err++;
      $display("FAIL div0_return_idle: got Done=%b Div0=%b, expected 0/0", Done, Div0);
    end
  endtask

  task automatic test_start_held();
    int bn, dn, restart;
    bn = 0; dn = 0; restart = 0;
    @(negedge Clk);
    Dividend = 8'd100;
    Divisor  = 8'd9;
    Start    = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge Clk); #1;
      Dividend = 8'($urandom);
      Divisor  = 8'($urandom);
      if (Busy === 1'b1) bn++;
      if (Done === 1'b1) dn++;
      if (Busy === 1'b1 && dn > 0) restart++;
    end
    n_vec++;
    if (bn !== 8 || dn !== 12 || restart !== 0) begin
      n_err++;
      $display("FAIL held_handshake: got busy=%0d done=%0d restart=%0d, expected 8/12/0",
               bn, dn, restart);
    end
    n_vec++;
    if (Quotient !== 8'd11 || Remainder !== 8'd1 || Done !== 1'b1) begin
      n_err++;
      $display("FAIL held_result: got Q=%0d R=%0d Done=%b, expected Q=11 R=1 Done=1",
               Quotient, Remainder, Done);
    end
    @(negedge Clk);
    Start = 1'b0;
    @(posedge Clk); #1;
    n_vec++;
    if (Done !== 1'b0) begin
      n_err++;
      $display("FAIL held_release: got Done=%b, expected 0", Done);
    end
  endtask

  task automatic test_reset_mid_calc();
    int cyc, bn;
    @(negedge Clk);
    Dividend = 8'd200;
    Divisor  = 8'd7;
    Start    = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    n_vec++;
    if (Busy !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_pre: got Busy=%b, expected 1", Busy);
    end
    Reset_n = 1'b0;
    #1;
    n_vec++;
    if ({Quotient, Remainder, Busy, Done, Div0} !== 19'd0) begin
      n_err++;
      $display("FAIL midreset_outputs: got Q=%h R=%h B=%b D=%b Z=%b, expected all 0",
               Quotient, Remainder, Busy, Done, Div0);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    do_div(8'd17, 8'd4, cyc, bn);
    n_vec++;
    if (cyc !== 8 || Quotient !== 8'd4 || Remainder !== 8'd1) begin
      n_err++;
      $display("FAIL midreset_after: got cycles=%0d Q=%0d R=%0d, expected 8 Q=4 R=1",
               cyc, Quotient, Remainder);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    int cyc, bn, exp_cyc;
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      exp_cyc = (b == 8'd0) ? 0 : 8;
      do_div(a, b, cyc, bn);
      n_vec++;
      if (cyc !== exp_cyc || bn !== exp_cyc || Quotient !== ref_q(a, b) ||
          Remainder !== ref_r(a, b) || Div0 !== (b == 8'd0)) begin
        n_err++;
        $display("FAIL rand %0d/%0d: got cyc=%0d busy=%0d Q=%0d R=%0d Z=%b, expected cyc=%0d Q=%0d R=%0d Z=%b",
                 a, b, cyc, bn, Quotient, Remainder, Div0, exp_cyc, ref_q(a, b), ref_r(a, b), (b == 8'd0));
      end
      // Back-to-back: next Start lands on the edge right after Done falls.
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div0();
    test_start_held();
    test_reset_mid_calc();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
